// File: rtl/ahb_lite_manager_fsm.sv
// AHB-Lite manager: one SINGLE transfer at a time from a valid/ready request port,
// result returned on a valid/ready response port. Optional wait-state timeout: AHB_MANAGER_TIMEOUT_EN.
module ahb_lite_manager_fsm #(
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic                    req_write,
    input  logic [2:0]              req_size,
    input  logic [DataWidth-1:0]    req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic [AddressWidth-1:0] haddr,
    output logic [1:0]              htrans,
    output logic [2:0]              hsize,
    output logic                    hwrite,
    output logic [2:0]              hburst,
    output logic [3:0]              hprot,
    output logic [DataWidth-1:0]    hwdata,
    input  logic                    hready,
    input  logic                    hresp,
    input  logic [DataWidth-1:0]    hrdata,
    output logic                    timeout,
    output logic [2:0]              dbg_state
);

    // Request and response ports: a beat moves on a rising edge where valid && ready;
    // the source holds valid and its payload stable until that edge.
    localparam int Bytes   = DataWidth / 8;
    localparam int MaxSize = $clog2(Bytes);
    localparam int OffW    = (MaxSize > 0) ? MaxSize : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [AddressWidth-1:0] addr_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [DataWidth-1:0]    rdata_q;
    logic                    err_q;
    logic                    req_fire;
    logic                    rsp_fire;
    logic                    req_bad;
    logic                    timeout_hit;
    logic [3:0]              low_mask;

    // Byte lanes [addr % Bytes .. + 2^size - 1] of the data bus.
    function automatic logic [DataWidth-1:0] lane_mask(input logic [AddressWidth-1:0] a,
                                                       input logic [2:0] s);
        int off;
        int n;
        lane_mask = '0;
        off = int'(a[OffW-1:0]) & (Bytes - 1);
        n = 1 << s;
        for (int b = 0; b < Bytes; b++) begin
            if (b >= off && b < off + n) lane_mask[b*8 +: 8] = 8'hFF;
        end
    endfunction

    assign req_ready = hresetn && (state_q == ST_IDLE);
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign low_mask  = (4'd1 << req_size) - 4'd1;
    assign req_bad   = (req_size > 3'(MaxSize)) || (({1'b0, req_addr[2:0]} & low_mask) != 4'd0);

    assign haddr     = addr_q;
    assign hsize     = size_q;
    assign hwrite    = write_q;
    assign hwdata    = wdata_q;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;
    assign dbg_state = state_q;

`ifdef AHB_MANAGER_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;
    logic            rsp_pend_q;
    logic [1:0]      drain_phase_q;  // 2: address phase pending, 1: data phase pending, 0: bus done
    logic            drain_done;

    assign timeout_hit = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !hready &&
                         (cnt_q == CntW'(TimeoutCycles - 1));
    assign drain_done  = ((drain_phase_q == 2'd0) || (drain_phase_q == 2'd1 && hready)) &&
                         (!rsp_pend_q || rsp_fire);
    assign timeout     = timeout_q;
    assign htrans      = ((state_q == ST_ADDR) || (state_q == ST_DRAIN && drain_phase_q == 2'd2))
                         ? 2'b10 : 2'b00;
    assign rsp_valid   = (state_q == ST_RESP) || (state_q == ST_DRAIN && rsp_pend_q);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            rsp_pend_q    <= 1'b0;
            drain_phase_q <= 2'd0;
        end else begin
            if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && !hready) cnt_q <= cnt_q + 1'b1;
            else                                                         cnt_q <= '0;
            if (timeout_hit) begin
                timeout_q     <= 1'b1;
                rsp_pend_q    <= 1'b1;
                drain_phase_q <= (state_q == ST_ADDR) ? 2'd2 : 2'd1;
            end else if (state_q == ST_DRAIN) begin
                if (rsp_fire) rsp_pend_q <= 1'b0;
                if (hready && drain_phase_q != 2'd0) drain_phase_q <= drain_phase_q - 2'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
    assign htrans      = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    assign rsp_valid   = (state_q == ST_RESP);
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_fire) state_d = req_bad ? ST_RESP : ST_ADDR;
            ST_ADDR: begin
                if (timeout_hit) state_d = ST_DRAIN;
                else if (hready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (timeout_hit) state_d = ST_DRAIN;
                else if (hready) state_d = ST_RESP;
            end
            ST_RESP: if (rsp_fire) state_d = ST_IDLE;
`ifdef AHB_MANAGER_TIMEOUT_EN
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                size_q  <= req_size;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= req_bad;
            end
            // Second cycle of an ERROR response lands here with hresp=1; data is dropped.
            if (state_q == ST_DATA && hready) begin
                err_q   <= hresp;
                rdata_q <= (write_q || hresp) ? '0 : (hrdata & lane_mask(addr_q, size_q));
            end
            if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_manager_fsm.sv
// Directed bench for ahb_lite_manager_fsm: the bench plays the AHB subordinate and
// checks bus and response behaviour against a transfer-level model every cycle.
module tb_ahb_lite_manager_fsm;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic          hwrite;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata, hrdata;
    logic          hready, hresp, timeout;
    logic [2:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_err_q[$];
    int            exp_phase = 0;   // 0 no bus phase, 1 address phase, 2 data phase
    logic          exp_busy = 1'b0;
    logic          exp_timeout = 1'b0;
    logic          mon_en = 1'b0;
    logic [AW-1:0] cur_addr;
    logic [2:0]    cur_size;
    logic          cur_write;
    logic [DW-1:0] cur_wdata;
    logic [DW-1:0] last_rdata;
    logic          last_err;

    ahb_lite_manager_fsm #(.AddressWidth(AW), .DataWidth(DW), .TimeoutCycles(8)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transfer-level model: what the response must be for one request.
    function automatic void model(input logic [AW-1:0] a, input logic w, input logic [2:0] s,
                                  input logic [DW-1:0] bus_data, input logic bus_err,
                                  output logic [DW-1:0] d, output logic e, output logic on_bus);
        int nbytes;
        int off;
        int nbits;
        logic [63:0] field;
        nbytes = DW / 8;
        d = '0;
        e = 1'b0;
        on_bus = 1'b1;
        if ((1 << s) > nbytes || (a % (1 << s)) != 0) begin
            on_bus = 1'b0;
            e = 1'b1;
            return;
        end
        if (bus_err) begin
            e = 1'b1;
        end else if (!w) begin
            off = int'(a % nbytes);
            nbits = 8 * (1 << s);
            field = 64'(bus_data) >> (8 * off);
            field = field & ((64'd1 << nbits) - 64'd1);
            d = DW'(field << (8 * off));
        end
    endfunction

    // scoreboard / compare process
    always @(negedge hclk) begin
        if (mon_en && hresetn) begin
            check("hburst", 64'(hburst), 64'd0);
            check("hprot", 64'(hprot), 64'd3);
            check("req_ready", 64'(req_ready), 64'(!exp_busy));
            check("htrans", 64'(htrans), (exp_phase == 1) ? 64'd2 : 64'd0);
            check("timeout", 64'(timeout), 64'(exp_timeout));
            if (exp_phase == 1) begin
                check("haddr", 64'(haddr), 64'(cur_addr));
                check("hsize", 64'(hsize), 64'(cur_size));
                check("hwrite", 64'(hwrite), 64'(cur_write));
            end
            if (exp_phase == 2 && cur_write) check("hwdata", 64'(hwdata), 64'(cur_wdata));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got response 0x%0h expected none", rsp_rdata);
                end else begin
                    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q.pop_front()));
                    check("rsp_error", 64'(rsp_error), 64'(exp_err_q.pop_front()));
                end
                last_rdata = rsp_rdata;
                last_err = rsp_error;
            end
        end
    end

    // driver tasks (all entered and left just after a rising edge)
    task automatic start_req(input logic [AW-1:0] a, input logic w, input logic [2:0] s,
                             input logic [DW-1:0] wd, input logic [DW-1:0] bus_data,
                             input logic bus_err, output logic on_bus);
        logic [DW-1:0] d;
        logic e;
        int n;
        model(a, w, s, bus_data, bus_err, d, e, on_bus);
        @(negedge hclk);
        req_valid = 1'b1;
        req_addr = a;
        req_write = w;
        req_size = s;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge hclk);
            n++;
        end
        if (!req_ready) check("accept_bound", 64'(req_ready), 64'd1);
        @(posedge hclk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom;
        req_wdata = $urandom;
        exp_q.push_back(d);
        exp_err_q.push_back(e);
        cur_addr = a;
        cur_size = s;
        cur_write = w;
        cur_wdata = wd;
        exp_busy = 1'b1;
        exp_phase = on_bus ? 1 : 0;
    endtask

    task automatic addr_phase(input int waits);
        for (int i = 0; i <= waits; i++) begin
            hready = (i == waits);
            hrdata = $urandom;
            @(posedge hclk);
            #1;
        end
        hready = 1'b1;
        exp_phase = 2;
    endtask

    task automatic data_phase(input int waits, input logic [DW-1:0] d, input logic err);
        for (int i = 0; i < waits; i++) begin
            hready = 1'b0;
            hresp = 1'b0;
            hrdata = $urandom;
            @(posedge hclk);
            #1;
        end
        if (err) begin
            hready = 1'b0;
            hresp = 1'b1;
            @(posedge hclk);
            #1;
            hready = 1'b1;
            hrdata = $urandom;
        end else begin
            hready = 1'b1;
            hresp = 1'b0;
            hrdata = d;
        end
        @(posedge hclk);
        #1;
        hready = 1'b1;
        hresp = 1'b0;
        hrdata = $urandom;
        exp_phase = 0;
    endtask

    task automatic finish_rsp(input int delay);
        for (int i = 0; i < delay; i++) begin
            rsp_ready = 1'b0;
            @(negedge hclk);
            check("rsp_hold", 64'(rsp_valid), 64'd1);
            @(posedge hclk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge hclk);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge hclk);
        #1;
        rsp_ready = 1'b0;
        exp_busy = 1'b0;
        @(negedge hclk);
        check("rsp_drop", 64'(rsp_valid), 64'd0);
        @(posedge hclk);
        #1;
    endtask

    task automatic do_xfer(input string name, input logic [AW-1:0] a, input logic w,
                           input logic [2:0] s, input logic [DW-1:0] wd,
                           input logic [DW-1:0] bus_data, input logic err,
                           input int aw, input int dw, input int delay,
                           input logic [DW-1:0] lit_rdata, input logic lit_err);
        logic on_bus;
        start_req(a, w, s, wd, bus_data, err, on_bus);
        if (on_bus) begin
            addr_phase(aw);
            data_phase(dw, bus_data, err);
        end
        finish_rsp(delay);
        check({name, "_rdata"}, 64'(last_rdata), 64'(lit_rdata));
        check({name, "_error"}, 64'(last_err), 64'(lit_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_htrans"}, 64'(htrans), 64'd0);
        check({tag, "_haddr"}, 64'(haddr), 64'd0);
        check({tag, "_hsize"}, 64'(hsize), 64'd0);
        check({tag, "_hwrite"}, 64'(hwrite), 64'd0);
        check({tag, "_hwdata"}, 64'(hwdata), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        logic on_bus;
        hresetn = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_write = 1'b0;
        req_size = 3'd0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        hready = 1'b1;
        hresp = 1'b0;
        hrdata = '0;
        #12;
        check_all_zero("reset");
        repeat (2) @(posedge hclk);
        #1;
        hresetn = 1'b1;
        mon_en = 1'b1;

        do_xfer("rd_word", 32'h1000, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 0,
                32'hDEADBEEF, 1'b0);
        do_xfer("wr_wait", 32'h2004, 1'b1, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0, 0, 3, 1,
                32'h0, 1'b0);
        do_xfer("rd_byte", 32'h3003, 1'b0, 3'd0, 32'h0, 32'h11223344, 1'b0, 0, 0, 0,
                32'h11000000, 1'b0);
        do_xfer("rd_half", 32'h1002, 1'b0, 3'd1, 32'h0, 32'hA1B2C3D4, 1'b0, 2, 1, 2,
                32'hA1B20000, 1'b0);
        do_xfer("rd_err", 32'h4000, 1'b0, 3'd2, 32'h0, 32'h12345678, 1'b1, 0, 1, 0,
                32'h0, 1'b1);
        do_xfer("wr_err", 32'h4010, 1'b1, 3'd1, 32'h5555AAAA, 32'h0, 1'b1, 1, 0, 0,
                32'h0, 1'b1);
        do_xfer("unaligned", 32'h5002, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF, 1'b0, 0, 0, 0,
                32'h0, 1'b1);
        do_xfer("oversize", 32'h5000, 1'b0, 3'd3, 32'h0, 32'hFFFFFFFF, 1'b0, 0, 0, 1,
                32'h0, 1'b1);
        do_xfer("wr_byte", 32'h6001, 1'b1, 3'd0, 32'h0000AB00, 32'h0, 1'b0, 1, 1, 0,
                32'h0, 1'b0);

        // reset in the middle of a data phase abandons the transfer
        start_req(32'h7000, 1'b0, 3'd2, 32'h89ABCDEF, 32'h0, 1'b0, on_bus);
        addr_phase(0);
        hready = 1'b0;
        @(negedge hclk);
        #2;
        hresetn = 1'b0;
        mon_en = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        exp_err_q.delete();
        exp_phase = 0;
        exp_busy = 1'b0;
        hready = 1'b1;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(negedge hclk);
        check("post_reset_req_ready", 64'(req_ready), 64'd1);
        mon_en = 1'b1;
        @(posedge hclk);
        #1;
        do_xfer("after_reset", 32'h1004, 1'b0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0, 0, 0, 0,
                32'h0BADF00D, 1'b0);

`ifdef AHB_MANAGER_TIMEOUT_EN
        // subordinate stalls the address phase past the 8-cycle limit
        start_req(32'h8000, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, on_bus);
        hready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge hclk);
            check("to_wait_rsp_valid", 64'(rsp_valid), 64'd0);
            @(posedge hclk);
            #1;
        end
        exp_timeout = 1'b1;
        rsp_ready = 1'b1;
        @(negedge hclk);
        check("to_rsp_valid", 64'(rsp_valid), 64'd1);
        check("to_rsp_error", 64'(rsp_error), 64'd1);
        @(posedge hclk);
        #1;
        rsp_ready = 1'b0;
        @(negedge hclk);
        check("to_rsp_drop", 64'(rsp_valid), 64'd0);
        hready = 1'b1;
        @(posedge hclk);
        #1;
        exp_phase = 2;
        @(posedge hclk);
        #1;
        exp_phase = 0;
        exp_busy = 1'b0;
        do_xfer("after_timeout", 32'h1008, 1'b0, 3'd2, 32'h0, 32'h600DCAFE, 1'b0, 0, 0, 0,
                32'h600DCAFE, 1'b0);
`endif

        if (exp_q.size() != 0) check("leftover_responses", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
